// File: rtl/implication_queue_if.sv
// Implication handshake bundle between the unit-clause evaluator (producer),
// the implication queue and the assignment stage (consumer).
//
// Both channels use one valid/ready rule: a transfer happens on a rising
// clock edge where valid and ready are both high. The receiver may change
// ready at any time. The queue holds the head steady while out_valid is
// high and out_ready is low.
//
//   in_valid/in_var/in_val   : producer -> queue, offered implication
//   in_ready                 : queue -> producer, implication accepted this cycle
//   out_valid/out_var/out_val: queue -> consumer, head implication
//   out_ready                : consumer -> queue, head consumed this cycle
//
// Modports:
//   master : the environment side (drives pushes, accepts pops)
//   slave  : the queue side
interface implication_queue_if #(
  parameter int VARIABLE_INDEX = 6
);
  logic                  in_valid;
  logic [VARIABLE_INDEX:0] in_var;
  logic                  in_val;
  logic                  in_ready;
  logic                  out_valid;
  logic [VARIABLE_INDEX:0] out_var;
  logic                  out_val;
  logic                  out_ready;

  modport master (
    output in_valid, in_var, in_val, out_ready,
    input  in_ready, out_valid, out_var, out_val
  );

  modport slave (
    input  in_valid, in_var, in_val, out_ready,
    output in_ready, out_valid, out_var, out_val
  );
endinterface

// File: rtl/implication_queue.sv
// Implication queue for a SAT solver datapath.
//
// A circular FIFO of (variable, value) implications with a per-variable
// pending table. A new implication for a variable that is already pending
// with the same value is dropped as a duplicate; one with the opposite value
// raises a sticky conflict and freezes the queue until flush (backtrack).
//
// Ports:
//   clock        : sole clock, rising edge
//   reset        : asynchronous, active-high
//   bus          : implication_queue_if.slave (push and pop channels)
//   flush        : discard all pending implications and clear conflict
//   conflict     : sticky conflict flag
//   conflict_var : variable whose opposite implication caused the conflict
//   count        : occupied entries, 0..DEPTH
//   state_dbg    : current FSM state (0 = RUN, 1 = CONFLICT)
module implication_queue #(
  parameter int NUM_VARIABLE   = 128,
  parameter int VARIABLE_INDEX = 6,
  parameter int DEPTH          = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  implication_queue_if.slave        bus,
  input  logic                      flush,
  output logic                      conflict,
  output logic [VARIABLE_INDEX:0]   conflict_var,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      state_dbg
);

  localparam int VW = VARIABLE_INDEX + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_CONFLICT = 1'b1
  } state_t;

  // Registered state
  state_t                  state_q, state_d;
  logic [PW-1:0]           head_q, head_d;
  logic [PW-1:0]           tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d;
  logic [VW-1:0]           conflict_var_q, conflict_var_d;
  logic [NUM_VARIABLE-1:0] pend_q, pend_d;
  logic [NUM_VARIABLE-1:0] pend_val_q, pend_val_d;
  logic [VW-1:0]           mem_var_q [DEPTH];
  logic [VW-1:0]           mem_var_d [DEPTH];
  logic                    mem_val_q [DEPTH];
  logic                    mem_val_d [DEPTH];

  // Handshake and lookup decode
  logic          in_ready_int;
  logic          out_valid_int;
  logic          push;
  logic          pop;
  logic          hit;
  logic          same_val;
  logic          enq;
  logic          clash;
  logic [VW-1:0] head_var;
  logic          head_val;

  always_comb begin
    // in_ready is held low while reset is asserted so the producer never
    // sees an acceptance that cannot complete.
    in_ready_int  = !reset && (state_q == ST_RUN) && (count_q != FULL) && !flush;
    out_valid_int = (state_q == ST_RUN) && (count_q != '0);
    push          = bus.in_valid && in_ready_int;
    // A flush cycle discards everything, so a same-cycle pop must not count.
    pop           = out_valid_int && bus.out_ready && !flush;
    // Lookup uses the registered table, i.e. the view before any same-cycle
    // pop clears the popped variable.
    hit           = pend_q[bus.in_var];
    same_val      = (pend_val_q[bus.in_var] == bus.in_val);
    enq           = push && !hit;
    clash         = push && hit && !same_val;
    head_var      = mem_var_q[head_q];
    head_val      = mem_val_q[head_q];
  end

  // Next-state: FSM, pointers, pending table and storage
  always_comb begin
    state_d        = state_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    conflict_var_d = conflict_var_q;
    pend_d         = pend_q;
    pend_val_d     = pend_val_q;
    mem_var_d      = mem_var_q;
    mem_val_d      = mem_val_q;

    if (flush) begin
      // Backtrack wins over anything else presented in the same cycle.
      state_d        = ST_RUN;
      head_d         = '0;
      tail_d         = '0;
      count_d        = '0;
      conflict_var_d = '0;
      pend_d         = '0;
      pend_val_d     = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (enq) begin
            mem_var_d[tail_q]      = bus.in_var;
            mem_val_d[tail_q]      = bus.in_val;
            tail_d                 = tail_q + PTR_ONE;
            pend_d[bus.in_var]     = 1'b1;
            pend_val_d[bus.in_var] = bus.in_val;
          end
          // A pending variable is always in the FIFO, and an enqueue only
          // happens for a non-pending variable, so the popped variable can
          // never be the one just enqueued.
          if (pop) begin
            head_d           = head_q + PTR_ONE;
            pend_d[head_var] = 1'b0;
          end
          count_d = count_q + CW'(enq) - CW'(pop);
          if (clash) begin
            state_d        = ST_CONFLICT;
            conflict_var_d = bus.in_var;
          end
        end
        ST_CONFLICT: begin
          // Frozen: no push (in_ready low) and no pop (out_valid low).
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_RUN;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      conflict_var_q <= '0;
      pend_q         <= '0;
      pend_val_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_var_q[i] <= '0;
        mem_val_q[i] <= 1'b0;
      end
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      conflict_var_q <= conflict_var_d;
      pend_q         <= pend_d;
      pend_val_q     <= pend_val_d;
      mem_var_q      <= mem_var_d;
      mem_val_q      <= mem_val_d;
    end
  end

  // Outputs
  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.out_var   = out_valid_int ? head_var : '0;
  assign bus.out_val   = out_valid_int ? head_val : 1'b0;
  assign conflict      = (state_q == ST_CONFLICT);
  assign conflict_var  = conflict_var_q;
  assign count         = count_q;
  assign state_dbg     = state_q;

endmodule
